// File: rtl/fib_stream_fifo.sv
// First-word-fall-through FIFO fed by the fibonacci generator's value stream.
// Each entry is tagged with a wrap flag, and samples that arrive while the FIFO is full are counted as drops.
module fib_stream_fifo #(
    parameter int WIDTH      = 16,
    parameter int DEPTH      = 8,
    parameter int DROP_WIDTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [WIDTH-1:0]         in_value,
    input  logic                     in_en,
    output logic [WIDTH-1:0]         out_data,
    output logic                     out_wrap,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     full,
    output logic [DROP_WIDTH-1:0]    drop_count,
    output logic                     wrap_seen
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;

    logic [WIDTH:0]          mem_r [DEPTH];
    logic [PTR_W-1:0]        wr_ptr_r;
    logic [PTR_W-1:0]        rd_ptr_r;
    logic [LVL_W-1:0]        level_r;
    logic                    full_r;
    logic                    valid_r;
    logic [DROP_WIDTH-1:0]   drop_r;
    logic                    wrap_seen_r;
    logic                    prev_valid_r;
    logic [WIDTH-1:0]        prev_value_r;

    logic                    pop_s;
    logic                    push_s;
    logic                    drop_s;
    logic                    wrap_s;
    logic [LVL_W-1:0]        level_next_s;
    logic [DROP_WIDTH-1:0]   drop_next_s;
    logic [WIDTH:0]          head_s;

    // Handshake decode, wrap detection and next-state for the occupancy and drop counters
    always_comb begin
        pop_s        = valid_r && out_ready;
        push_s       = in_en && (!full_r || pop_s);
        drop_s       = in_en && full_r && !pop_s;
        wrap_s       = 1'b0;
        level_next_s = level_r;
        drop_next_s  = drop_r;

        if (in_en && prev_valid_r && (in_value < prev_value_r)) begin
            wrap_s = 1'b1;
        end else begin
            wrap_s = 1'b0;
        end

        case ({push_s, pop_s})
            2'b10:   level_next_s = level_r + LVL_W'(1'b1);
            2'b01:   level_next_s = level_r - LVL_W'(1'b1);
            default: level_next_s = level_r;
        endcase

        if (drop_s && (drop_r != {DROP_WIDTH{1'b1}})) begin
            drop_next_s = drop_r + DROP_WIDTH'(1'b1);
        end else begin
            drop_next_s = drop_r;
        end
    end

    // Pointers, occupancy, status flags and sample history
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_r     <= {PTR_W{1'b0}};
            rd_ptr_r     <= {PTR_W{1'b0}};
            level_r      <= {LVL_W{1'b0}};
            full_r       <= 1'b0;
            valid_r      <= 1'b0;
            drop_r       <= {DROP_WIDTH{1'b0}};
            wrap_seen_r  <= 1'b0;
            prev_valid_r <= 1'b0;
            prev_value_r <= {WIDTH{1'b0}};
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1'b1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1'b1);
            end
            level_r     <= level_next_s;
            full_r      <= (level_next_s == LVL_W'(DEPTH));
            valid_r     <= (level_next_s != {LVL_W{1'b0}});
            drop_r      <= drop_next_s;
            wrap_seen_r <= wrap_seen_r | wrap_s;
            if (in_en) begin
                prev_valid_r <= 1'b1;
                prev_value_r <= in_value;
            end
        end
    end

    // Entry storage; when full, a simultaneous pop frees the slot that wr_ptr already points at
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= {wrap_s, in_value};
        end
    end

    // Stale memory contents are masked so the head reads as zero while the FIFO is empty
    assign head_s     = mem_r[rd_ptr_r];
    assign out_data   = valid_r ? head_s[WIDTH-1:0] : {WIDTH{1'b0}};
    assign out_wrap   = valid_r ? head_s[WIDTH] : 1'b0;
    assign out_valid  = valid_r;
    assign level      = level_r;
    assign full       = full_r;
    assign drop_count = drop_r;
    assign wrap_seen  = wrap_seen_r;

endmodule

// File: tb/tb_fib_stream_fifo.sv
// Directed bench for fib_stream_fifo: a default instance (16-bit data, 16-bit drop counter)
// and a narrow instance (8-bit data, 2-bit drop counter).
module tb_fib_stream_fifo;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic [15:0] in_value = 16'd0;
    logic        in_en = 1'b0;
    logic        out_ready = 1'b0;
    logic [15:0] out_data;
    logic        out_wrap;
    logic        out_valid;
    logic [3:0]  level;
    logic        full;
    logic [15:0] drop_count;
    logic        wrap_seen;

    logic [7:0]  s_in_value = 8'd0;
    logic        s_in_en = 1'b0;
    logic        s_out_ready = 1'b0;
    logic [7:0]  s_out_data;
    logic        s_out_wrap;
    logic        s_out_valid;
    logic [3:0]  s_level;
    logic        s_full;
    logic [1:0]  s_drop_count;
    logic        s_wrap_seen;

    int pass_cnt = 0;
    int total_cnt = 0;

    fib_stream_fifo dut (
        .clk(clk), .rst(rst), .in_value(in_value), .in_en(in_en),
        .out_data(out_data), .out_wrap(out_wrap), .out_valid(out_valid),
        .out_ready(out_ready), .level(level), .full(full),
        .drop_count(drop_count), .wrap_seen(wrap_seen)
    );

    fib_stream_fifo #(.WIDTH(8), .DEPTH(8), .DROP_WIDTH(2)) dut_small (
        .clk(clk), .rst(rst), .in_value(s_in_value), .in_en(s_in_en),
        .out_data(s_out_data), .out_wrap(s_out_wrap), .out_valid(s_out_valid),
        .out_ready(s_out_ready), .level(s_level), .full(s_full),
        .drop_count(s_drop_count), .wrap_seen(s_wrap_seen)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        in_en = 1'b0; out_ready = 1'b0; in_value = 16'd0;
        s_in_en = 1'b0; s_out_ready = 1'b0; s_in_value = 8'd0;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        total_cnt += 6;
        if (out_valid !== 1'b0) $display("FAIL reset_valid got %0b want 0", out_valid); else pass_cnt++;
        if (level !== 4'd0) $display("FAIL reset_level got %0d want 0", level); else pass_cnt++;
        if (full !== 1'b0) $display("FAIL reset_full got %0b want 0", full); else pass_cnt++;
        if (drop_count !== 16'd0) $display("FAIL reset_drop got %0d want 0", drop_count); else pass_cnt++;
        if (wrap_seen !== 1'b0) $display("FAIL reset_wrap_seen got %0b want 0", wrap_seen); else pass_cnt++;
        if (out_data !== 16'd0) $display("FAIL reset_data got %0d want 0", out_data); else pass_cnt++;
        rst = 1'b0;
    endtask

    task automatic test_fib_order();
        logic [15:0] fib [5];
        fib = '{16'd1, 16'd1, 16'd2, 16'd3, 16'd5};
        do_reset();
        for (int i = 0; i < 5; i++) begin
            in_value = fib[i]; in_en = 1'b1;
            tick();
        end
        in_en = 1'b0;
        total_cnt += 2;
        if (level !== 4'd5) $display("FAIL fib_level got %0d want 5", level); else pass_cnt++;
        if (wrap_seen !== 1'b0) $display("FAIL fib_wrap_seen got %0b want 0", wrap_seen); else pass_cnt++;
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            total_cnt += 2;
            if (out_data !== fib[i]) $display("FAIL fib_data[%0d] got %0d want %0d", i, out_data, fib[i]); else pass_cnt++;
            if (out_wrap !== 1'b0) $display("FAIL fib_wrap[%0d] got %0b want 0", i, out_wrap); else pass_cnt++;
            tick();
        end
        out_ready = 1'b0;
        total_cnt += 2;
        if (out_valid !== 1'b0) $display("FAIL fib_empty_valid got %0b want 0", out_valid); else pass_cnt++;
        if (level !== 4'd0) $display("FAIL fib_empty_level got %0d want 0", level); else pass_cnt++;
    endtask

    task automatic test_overflow();
        do_reset();
        for (int i = 0; i < 11; i++) begin
            in_value = 16'(10 + i); in_en = 1'b1;
            tick();
        end
        in_en = 1'b0;
        total_cnt += 3;
        if (full !== 1'b1) $display("FAIL ovf_full got %0b want 1", full); else pass_cnt++;
        if (level !== 4'd8) $display("FAIL ovf_level got %0d want 8", level); else pass_cnt++;
        if (drop_count !== 16'd3) $display("FAIL ovf_drop got %0d want 3", drop_count); else pass_cnt++;
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            total_cnt++;
            if (out_data !== 16'(10 + i)) $display("FAIL ovf_data[%0d] got %0d want %0d", i, out_data, 10 + i); else pass_cnt++;
            tick();
        end
        out_ready = 1'b0;
        total_cnt++;
        if (full !== 1'b0) $display("FAIL ovf_drained_full got %0b want 0", full); else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        do_reset();
        for (int i = 0; i < 8; i++) begin
            in_value = 16'(100 + i); in_en = 1'b1;
            tick();
        end
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_value = 16'(108 + i); in_en = 1'b1;
            total_cnt += 2;
            if (out_data !== 16'(100 + i)) $display("FAIL b2b_head[%0d] got %0d want %0d", i, out_data, 100 + i); else pass_cnt++;
            if (level !== 4'd8) $display("FAIL b2b_level[%0d] got %0d want 8", i, level); else pass_cnt++;
            tick();
        end
        in_en = 1'b0;
        total_cnt += 3;
        if (level !== 4'd8) $display("FAIL b2b_level_end got %0d want 8", level); else pass_cnt++;
        if (full !== 1'b1) $display("FAIL b2b_full got %0b want 1", full); else pass_cnt++;
        if (drop_count !== 16'd0) $display("FAIL b2b_drop got %0d want 0", drop_count); else pass_cnt++;
        for (int i = 0; i < 8; i++) begin
            total_cnt++;
            if (out_data !== 16'(104 + i)) $display("FAIL b2b_drain[%0d] got %0d want %0d", i, out_data, 104 + i); else pass_cnt++;
            tick();
        end
        out_ready = 1'b0;
    endtask

    task automatic test_wrap_narrow();
        logic [7:0] vals [3];
        logic       wraps [3];
        vals = '{8'd144, 8'd233, 8'd121};
        wraps = '{1'b0, 1'b0, 1'b1};
        do_reset();
        for (int i = 0; i < 3; i++) begin
            s_in_value = vals[i]; s_in_en = 1'b1;
            tick();
        end
        s_in_en = 1'b0;
        total_cnt++;
        if (s_wrap_seen !== 1'b1) $display("FAIL wrap_seen_narrow got %0b want 1", s_wrap_seen); else pass_cnt++;
        s_out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            total_cnt += 2;
            if (s_out_data !== vals[i]) $display("FAIL wrap_data[%0d] got %0d want %0d", i, s_out_data, vals[i]); else pass_cnt++;
            if (s_out_wrap !== wraps[i]) $display("FAIL wrap_flag[%0d] got %0b want %0b", i, s_out_wrap, wraps[i]); else pass_cnt++;
            tick();
        end
        s_out_ready = 1'b0;
    endtask

    task automatic test_drop_wrap();
        do_reset();
        for (int i = 0; i < 8; i++) begin
            in_value = 16'(50 + i); in_en = 1'b1;
            tick();
        end
        in_value = 16'd5; in_en = 1'b1;
        tick();
        in_en = 1'b0;
        total_cnt += 2;
        if (wrap_seen !== 1'b1) $display("FAIL dropwrap_seen got %0b want 1", wrap_seen); else pass_cnt++;
        if (drop_count !== 16'd1) $display("FAIL dropwrap_drop got %0d want 1", drop_count); else pass_cnt++;
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            total_cnt += 2;
            if (out_data !== 16'(50 + i)) $display("FAIL dropwrap_data[%0d] got %0d want %0d", i, out_data, 50 + i); else pass_cnt++;
            if (out_wrap !== 1'b0) $display("FAIL dropwrap_flag[%0d] got %0b want 0", i, out_wrap); else pass_cnt++;
            tick();
        end
        out_ready = 1'b0;
    endtask

    task automatic test_async_reset();
        do_reset();
        for (int i = 0; i < 8; i++) begin
            in_value = 16'(200 + 10 * i); in_en = 1'b1;
            tick();
        end
        in_value = 16'd150; in_en = 1'b1;
        tick();
        in_en = 1'b0; out_ready = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        out_ready = 1'b0;
        total_cnt += 3;
        if (level !== 4'd5) $display("FAIL arst_pre_level got %0d want 5", level); else pass_cnt++;
        if (drop_count !== 16'd1) $display("FAIL arst_pre_drop got %0d want 1", drop_count); else pass_cnt++;
        if (wrap_seen !== 1'b1) $display("FAIL arst_pre_wrap_seen got %0b want 1", wrap_seen); else pass_cnt++;
        #2 rst = 1'b1;
        #1;
        total_cnt += 4;
        if (out_valid !== 1'b0) $display("FAIL arst_valid got %0b want 0", out_valid); else pass_cnt++;
        if (level !== 4'd0) $display("FAIL arst_level got %0d want 0", level); else pass_cnt++;
        if (drop_count !== 16'd0) $display("FAIL arst_drop got %0d want 0", drop_count); else pass_cnt++;
        if (wrap_seen !== 1'b0) $display("FAIL arst_wrap_seen got %0b want 0", wrap_seen); else pass_cnt++;
        #2 rst = 1'b0;
        in_value = 16'd100; in_en = 1'b1;
        tick();
        in_en = 1'b0;
        total_cnt += 4;
        if (level !== 4'd1) $display("FAIL arst_post_level got %0d want 1", level); else pass_cnt++;
        if (out_data !== 16'd100) $display("FAIL arst_post_data got %0d want 100", out_data); else pass_cnt++;
        if (out_wrap !== 1'b0) $display("FAIL arst_post_wrap got %0b want 0", out_wrap); else pass_cnt++;
        if (wrap_seen !== 1'b0) $display("FAIL arst_post_wrap_seen got %0b want 0", wrap_seen); else pass_cnt++;
    endtask

    task automatic test_saturate();
        do_reset();
        for (int i = 0; i < 11; i++) begin
            s_in_value = 8'(1 + i); s_in_en = 1'b1;
            tick();
        end
        total_cnt++;
        if (s_drop_count !== 2'd3) $display("FAIL sat_drop3 got %0d want 3", s_drop_count); else pass_cnt++;
        for (int i = 0; i < 2; i++) begin
            s_in_value = 8'(12 + i); s_in_en = 1'b1;
            tick();
        end
        s_in_en = 1'b0;
        total_cnt += 2;
        if (s_drop_count !== 2'd3) $display("FAIL sat_drop5 got %0d want 3", s_drop_count); else pass_cnt++;
        if (s_full !== 1'b1) $display("FAIL sat_full got %0b want 1", s_full); else pass_cnt++;
    endtask

    task automatic test_no_bypass();
        do_reset();
        in_value = 16'd77; in_en = 1'b1; out_ready = 1'b1;
        total_cnt++;
        if (out_valid !== 1'b0) $display("FAIL nobyp_pre_valid got %0b want 0", out_valid); else pass_cnt++;
        tick();
        in_en = 1'b0; out_ready = 1'b0;
        total_cnt += 3;
        if (level !== 4'd1) $display("FAIL nobyp_level got %0d want 1", level); else pass_cnt++;
        if (out_valid !== 1'b1) $display("FAIL nobyp_valid got %0b want 1", out_valid); else pass_cnt++;
        if (out_data !== 16'd77) $display("FAIL nobyp_data got %0d want 77", out_data); else pass_cnt++;
        for (int i = 0; i < 2; i++) begin
            tick();
            total_cnt++;
            if (out_data !== 16'd77) $display("FAIL hold_data[%0d] got %0d want 77", i, out_data); else pass_cnt++;
        end
    endtask

    initial begin
        test_reset();
        test_fib_order();
        test_overflow();
        test_back_to_back();
        test_wrap_narrow();
        test_drop_wrap();
        test_async_reset();
        test_saturate();
        test_no_bypass();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/fib_stream_fifo.md
Name: fib_stream_fifo

Overview:
- Downstream consumer of the fibonacci generator's `value` stream.
- Samples one value per enabled cycle into a first-word-fall-through FIFO and presents it on a valid/ready output interface.
- Tags each entry with a wrap flag (value smaller than the previous sample, i.e. generator arithmetic overflowed).
- The generator has no backpressure, so overflowing samples are dropped and counted.

Parameters:
- WIDTH, 16, data width; equals the generator's COUNTER_WIDTH.
- DEPTH, 8, number of FIFO entries; power of two, >= 2.
- DROP_WIDTH, 16, width of the saturating drop counter.

Ports:
- clk  input  1  clock; all state updates on posedge.
- rst  input  1  asynchronous, active-high reset.
- in_value  input  WIDTH  sample from the generator's `value`.
- in_en  input  1  sample in_value this cycle.
- out_data  output  WIDTH  FIFO head value.
- out_wrap  output  1  wrap flag of the head entry.
- out_valid  output  1  head entry is valid.
- out_ready  input  1  consumer accepts head when out_valid is high.
- level  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
- full  output  1  level == DEPTH.
- drop_count  output  DROP_WIDTH  samples dropped, saturating.
- wrap_seen  output  1  sticky: some sample, stored or dropped, had wrap=1.

Behaviour:
- Reset (async assert; synchronous-to-clk release is the integrator's job):
  - rd/wr pointers = 0, level = 0, out_valid = 0, full = 0.
  - drop_count = 0, wrap_seen = 0, prev_valid = 0, prev_value = 0.
  - out_data and out_wrap read as 0 while empty: memory is reset, or the outputs are masked.
- Storage: DEPTH x (WIDTH+1) register array of {wrap, value}. Pointers are $clog2(DEPTH) bits and wrap modulo DEPTH naturally. Occupancy is tracked by the level register.
- Wrap detection, evaluated when in_en=1:
  - wrap = prev_valid && (in_value < prev_value), unsigned compare.
  - Equal values (e.g. 1,1) give wrap=0.
  - prev_value <= in_value and prev_valid <= 1 on every in_en cycle, whether or not the sample is stored.
  - wrap_seen <= wrap_seen | wrap.
- Pop: pop = out_valid && out_ready. It advances rd pointer on the edge.
- Push: push = in_en && (!full || pop).
  - When full, a push is accepted in the same cycle as a pop; the write lands in the slot freed by the pop.
- Drop: in_en && full && !pop.
  - Increment drop_count, saturating at all-ones.
  - Sample not stored; prev_value still updated.
- Level update: level += push - pop. Push and pop together leave level unchanged.
- Output timing: first-word-fall-through.
  - out_valid = (level != 0), driven from registers.
  - out_data/out_wrap = mem[rd pointer], combinational from registered state.
  - A sample pushed at edge N is visible on the outputs after edge N. Latency is 1 cycle when empty.
- Empty FIFO with in_en=1 and out_ready=1: no bypass. The sample is stored; pop does not occur because out_valid=0.
- out_data must stay stable while out_valid=1 and out_ready=0.
- Reset mid-operation discards all contents, counters and wrap history immediately (asynchronous).
- No combinational path from in_* to out_*; out_valid depends only on state.

Test Plan:
- Reset, then in_en=1 with in_value 1,1,2,3,5 and out_ready=0 -> level reaches 5. After out_ready=1, reads 1,1,2,3,5, all out_wrap=0.
- Fill DEPTH=8 with out_ready=0, then 3 more in_en cycles -> full=1, drop_count=3. Contents are the first 8 samples.
- Full FIFO, in_en=1 and out_ready=1 for 4 cycles -> drop_count unchanged, level stays 8. Each popped word is replaced in order.
- WIDTH=8, samples 144,233,121 -> the 121 entry reads out_wrap=1 and wrap_seen=1. The 233 entry reads out_wrap=0.
- Drop a wrapping sample while full -> wrap_seen=1 and drop_count increments. No stored entry has out_wrap=1.
- Assert rst asynchronously mid-stream with level=5 -> out_valid, level, drop_count and wrap_seen are 0 before the next clk edge. The first sample after release gets wrap=0 even if smaller than the pre-reset value.
- DROP_WIDTH=2 with 5 drops -> drop_count saturates at 3.
